// File: rtl/seg7_pkg.sv
// Seven-segment patterns (g..a, active-high) and digit slot indices shared by
// the display multiplexer and its decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Any value above 9 decodes to a dash; this one is used to force it.
  localparam logic [3:0] VAL_DASH = 4'hF;

  typedef enum logic [1:0] {
    DIG_MIN0 = 2'd0,
    DIG_MIN1 = 2'd1,
    DIG_HR0  = 2'd2,
    DIG_HR1  = 2'd3
  } dig_idx_e;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high seven-segment pattern; values above 9 show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (val_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_mux.sv
// Four-digit multiplexed common-anode display driver for HH:MM with blinking
// colon, leading-zero blanking, anti-ghost guard slots and alarm flashing.
module time_display_mux
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 16,
  parameter int FLASH_CYCLES = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] hour_in1,
  input  logic [3:0] hour_in0,
  input  logic [3:0] minute_in1,
  input  logic [3:0] minute_in0,
  input  logic [5:0] seconds,
  input  logic       alarm,
  input  logic       blank_leading,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_start
);

  localparam int SCAN_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  dig_idx_e           idx_q, idx_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               flash_phase_q, flash_phase_d;
  logic               init_q;

  logic [1:0] snap_hr1_q;
  logic [3:0] snap_hr0_q, snap_min1_q, snap_min0_q;
  logic       snap_sec0_q;

  logic [3:0] an_n_q, an_n_d;
  logic [6:0] seg_n_q, seg_n_d;
  logic       dp_n_q, dp_n_d;
  logic       frame_start_q;

  logic       scan_wrap;
  logic       snap_take;
  logic       lead_blank;
  logic [3:0] dig_val;
  logic [6:0] dig_seg;
  logic       unused_seconds;

  assign unused_seconds = ^seconds[5:1];

  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_W'(DIGIT_CYCLES - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d      = scan_wrap ? dig_idx_e'(idx_q + 2'd1) : idx_q;
    // A new frame starts when the last digit slot rolls over to the first.
    snap_take  = init_q || (scan_wrap && (idx_q == DIG_HR1));
  end

  always_comb begin
    flash_cnt_d   = '0;
    flash_phase_d = 1'b0;
    if (alarm) begin
      if (flash_cnt_q == FLASH_W'(FLASH_CYCLES - 1)) begin
        flash_cnt_d   = '0;
        flash_phase_d = ~flash_phase_q;
      end else begin
        flash_cnt_d   = flash_cnt_q + 1'b1;
        flash_phase_d = flash_phase_q;
      end
    end
  end

  always_comb begin
    dig_val = snap_min0_q;
    case (idx_q)
      DIG_MIN0: dig_val = snap_min0_q;
      DIG_MIN1: dig_val = snap_min1_q;
      DIG_HR0:  dig_val = snap_hr0_q;
      DIG_HR1:  dig_val = (snap_hr1_q == 2'd3) ? VAL_DASH : {2'b00, snap_hr1_q};
      default:  dig_val = VAL_DASH;
    endcase
  end

  seg7_decode u_decode (
    .val_i (dig_val),
    .seg_o (dig_seg)
  );

  always_comb begin
    lead_blank = (idx_q == DIG_HR1) && blank_leading && (snap_hr1_q == 2'd0);
    if ((scan_cnt_q < SCAN_W'(GUARD_CYCLES)) || flash_phase_q || lead_blank) begin
      an_n_d = 4'b1111;
    end else begin
      an_n_d = ~(4'b0001 << idx_q);
    end
    seg_n_d = ~dig_seg;
    dp_n_d  = !((idx_q == DIG_HR0) && !snap_sec0_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt_q    <= '0;
      idx_q         <= DIG_MIN0;
      flash_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
      init_q        <= 1'b1;
      snap_hr1_q    <= '0;
      snap_hr0_q    <= '0;
      snap_min1_q   <= '0;
      snap_min0_q   <= '0;
      snap_sec0_q   <= 1'b0;
      an_n_q        <= 4'b1111;
      seg_n_q       <= ~SEG_BLANK;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_phase_q <= flash_phase_d;
      init_q        <= 1'b0;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= snap_take;
      if (snap_take) begin
        snap_hr1_q  <= hour_in1;
        snap_hr0_q  <= hour_in0;
        snap_min1_q <= minute_in1;
        snap_min0_q <= minute_in0;
        snap_sec0_q <= seconds[0];
      end
    end
  end

  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_time_display_mux.sv
// Self-checking bench for time_display_mux: table-driven frame checks, corner
// sequences, and a cycle-level reference model checked on every cycle.
module tb_time_display_mux;

  localparam int D = 8;
  localparam int G = 2;
  localparam int F = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] hour_in1;
  logic [3:0] hour_in0, minute_in1, minute_in0;
  logic [5:0] seconds;
  logic       alarm, blank_leading;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n, frame_start;

  always #5 clock = ~clock;

  time_display_mux #(
    .DIGIT_CYCLES (D),
    .GUARD_CYCLES (G),
    .FLASH_CYCLES (F)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .hour_in1      (hour_in1),
    .hour_in0      (hour_in0),
    .minute_in1    (minute_in1),
    .minute_in0    (minute_in0),
    .seconds       (seconds),
    .alarm         (alarm),
    .blank_leading (blank_leading),
    .an_n          (an_n),
    .seg_n         (seg_n),
    .dp_n          (dp_n),
    .frame_start   (frame_start)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Reference model: position in the 4*D-cycle frame, snapshot, alarm run length.
  int         k;
  int         arun;
  logic [3:0] snap_v [4];
  logic       snap_s0;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_fs;

  typedef struct {
    logic [1:0]      hr1;
    logic [3:0]      hr0;
    logic [3:0]      m1;
    logic [3:0]      m0;
    logic [5:0]      sec;
    logic            blank;
    logic [3:0][6:0] segs;
    logic            dark3;
  } vec_t;

  vec_t vt [5];

  function automatic logic [6:0] pat(input int v);
    case (v)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int scan, idx, v;
    bit ph;
    logic [6:0] p;
    if (reset) begin
      k = 0; arun = 0;
      for (int i = 0; i < 4; i++) snap_v[i] = 4'd0;
      snap_s0 = 1'b0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
    end else begin
      scan = k % D;
      idx  = (k / D) % 4;
      ph   = ((arun / F) % 2) == 1;
      v    = int'(snap_v[idx]);
      if (idx == 3 && v == 3) v = 15;
      p       = pat(v);
      exp_seg = ~p;
      exp_dp  = !(idx == 2 && snap_s0 == 1'b0);
      if (scan < G || ph || (idx == 3 && blank_leading && snap_v[3] == 4'd0)) exp_an = 4'hF;
      else exp_an = ~(4'b0001 << idx);
      k++;
      exp_fs = (k == 1) || (k % (4 * D) == 0);
      if (exp_fs) begin
        snap_v[0] = minute_in0;
        snap_v[1] = minute_in1;
        snap_v[2] = hour_in0;
        snap_v[3] = {2'b00, hour_in1};
        snap_s0   = seconds[0];
      end
      arun = alarm ? arun + 1 : 0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    if (chk_en) begin
      check("model_an", an_n, exp_an);
      check("model_seg", seg_n, exp_seg);
      check("model_dp", dp_n, exp_dp);
      check("model_fs", frame_start, exp_fs);
    end
  endtask

  task automatic wait_fs();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (frame_start) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("frame_start_timeout", {31'd0, frame_start}, 32'd1);
  endtask

  task automatic set_time(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] mi1,
                          input logic [3:0] mi0, input logic [5:0] s, input logic bl);
    hour_in1 = h1; hour_in0 = h0; minute_in1 = mi1; minute_in0 = mi0;
    seconds = s; blank_leading = bl;
  endtask

  initial begin
    int lit1, lit3, slot, scan;
    logic [3:0] ea;

    vt[0] = '{2'd1, 4'd2, 4'd3, 4'd4,  6'd10, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
    vt[1] = '{2'd0, 4'd9, 4'd5, 4'd9,  6'd59, 1'b1, {7'h40, 7'h10, 7'h12, 7'h10}, 1'b1};
    vt[2] = '{2'd0, 4'd9, 4'd5, 4'd9,  6'd59, 1'b0, {7'h40, 7'h10, 7'h12, 7'h10}, 1'b0};
    vt[3] = '{2'd3, 4'd7, 4'd0, 4'd12, 6'd0,  1'b1, {7'h3F, 7'h78, 7'h40, 7'h3F}, 1'b0};
    vt[4] = '{2'd2, 4'd3, 4'd5, 4'd8,  6'd1,  1'b1, {7'h24, 7'h30, 7'h12, 7'h00}, 1'b0};

    reset = 1'b1; alarm = 1'b0;
    set_time(2'd0, 4'd0, 4'd0, 4'd0, 6'd0, 1'b0);
    step();
    chk_en = 1;

    // Reset held with arbitrary inputs.
    for (int i = 0; i < 3; i++) begin
      set_time(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
               6'($urandom), 1'($urandom));
      alarm = 1'($urandom);
      step();
      check("rst_an", an_n, 4'hF);
      check("rst_seg", seg_n, 7'h7F);
      check("rst_dp", dp_n, 1'b1);
      check("rst_fs", frame_start, 1'b0);
    end
    reset = 1'b0; alarm = 1'b0;
    step();
    check("first_frame_start", frame_start, 1'b1);

    // Table-driven full-frame checks.
    foreach (vt[v]) begin
      set_time(vt[v].hr1, vt[v].hr0, vt[v].m1, vt[v].m0, vt[v].sec, vt[v].blank);
      wait_fs();
      for (int j = 0; j < 4 * D; j++) begin
        step();
        slot = j / D;
        scan = j % D;
        if (scan < G || (slot == 3 && vt[v].dark3)) ea = 4'hF;
        else ea = ~(4'b0001 << slot);
        check($sformatf("vec%0d_an", v), an_n, ea);
        check($sformatf("vec%0d_seg", v), seg_n, vt[v].segs[slot]);
        check($sformatf("vec%0d_dp", v), dp_n, (slot == 2 && vt[v].sec[0] == 1'b0) ? 1'b0 : 1'b1);
      end
    end

    // Snapshot integrity: mid-frame change of minute units.
    set_time(2'd1, 4'd2, 4'd3, 4'd4, 6'd10, 1'b0);
    wait_fs();
    wait_fs();
    for (int j = 0; j < 5; j++) step();
    minute_in0 = 4'd5;
    for (int j = 0; j < 3; j++) begin
      step();
      check("snap_hold_seg", seg_n, 7'h19);
    end
    wait_fs();
    step();
    check("snap_new_seg", seg_n, 7'h12);

    // Alarm flash: 20 normal, 20 dark, 20 normal.
    wait_fs();
    alarm = 1'b1;
    lit1 = 0; lit3 = 0;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (n > 20 && n <= 40) check("flash_dark", an_n, 4'hF);
      else if (an_n != 4'hF) begin
        if (n <= 20) lit1++;
        else lit3++;
      end
    end
    check("flash_lit_before", {31'd0, lit1 > 0}, 32'd1);
    check("flash_lit_after", {31'd0, lit3 > 0}, 32'd1);
    alarm = 1'b0;
    step();

    // Drop alarm mid-dark: one more dark cycle, then back to normal.
    wait_fs();
    alarm = 1'b1;
    for (int n = 0; n < 25; n++) step();
    check("drop_was_dark", an_n, 4'hF);
    alarm = 1'b0;
    step();
    check("drop_lag_dark", an_n, 4'hF);
    step();
    check("drop_resume_an", an_n, 4'b0111);
    check("drop_resume_seg", seg_n, 7'h79);

    // Random stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: minute_in0 = 4'($urandom_range(0, 15));
          1: minute_in1 = 4'($urandom_range(0, 15));
          2: hour_in0   = 4'($urandom_range(0, 15));
          3: hour_in1   = 2'($urandom_range(0, 3));
          default: seconds = 6'($urandom_range(0, 63));
        endcase
      end
      if ($urandom_range(0, 99) == 0) blank_leading = ~blank_leading;
      if ($urandom_range(0, 39) == 0) alarm = ~alarm;
      reset = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
